serial_adder_sched: RTL and testbench

- Shares one SLICE_W-bit carry adder slice between REQS requesters.
- Sequences each DATA_W-bit add over DATA_W/SLICE_W cycles, chaining the carry between slices.
- Round-robin arbitration at the request side; valid/ready handshake on both request and response.
- Sits between client blocks and the shared adder datapath; replaces per-client wide adders where area matters.

---
 rtl/serial_adder_pkg.sv | 47 ++++
 rtl/adder_slice.sv | 22 ++
 rtl/serial_adder_sched.sv | 178 +++++++++++++++++
 tb/tb_serial_adder_sched.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the serial adder scheduler:
//   - state_e     : FSM encoding (IDLE / CALC / DONE)
//   - *_DEF       : default values for DATA_W, SLICE_W and REQS
//   - rr_pick()   : round-robin grant search over up to RR_MAX requesters
// ---------------------------------------------------------------------------
package serial_adder_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int SLICE_W_DEF = 2;
  localparam int REQS_DEF    = 2;

  // Widest request vector rr_pick can search.
  localparam int RR_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns the first index i with valid[i] set, searching upward from
  // (last + 1) mod n with wrap. Returns 0 when nothing is valid; callers
  // qualify the result with |valid.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] valid,
                                          input int unsigned        last,
                                          input int unsigned        n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    idx   = 0;
    found = 1'b0;
    for (int unsigned off = 1; off <= RR_MAX; off++) begin
      if (off <= n) begin
        idx = (last + off) % n;
        if (!found && valid[idx[4:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Purely combinational W-bit unsigned adder with carry in/out.
// Ports:
//   a_i, b_i  in  W  operands
//   cin_i     in  1  carry-in
//   sum_o     out W  a_i + b_i + cin_i (low W bits)
//   cout_o    out 1  carry-out
// ---------------------------------------------------------------------------
module adder_slice #(
  parameter int W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/serial_adder_sched.sv
// ---------------------------------------------------------------------------
// serial_adder_sched
// Shares one SLICE_W-bit adder slice between REQS requesters. Each DATA_W-bit
// add is walked over NSL = DATA_W/SLICE_W cycles with the carry registered
// between slices. Requesters are granted round-robin.
//
// Optional feature (macro SERIAL_ADDER_SCHED_SUB_EN): adds io_req_sub; a
// subtract request stores rhs inverted and forces carry-in to 1, giving
// lhs - rhs with io_resp_cout = 1 meaning "no borrow".
//
// Ports:
//   clk            in   1            rising-edge clock
//   reset          in   1            synchronous, active-low reset
//   io_req_valid   in   REQS         per-requester request valid
//   io_req_ready   out  REQS         accept, one-hot or zero, IDLE only
//   io_req_lhs     in   REQS*DATA_W  requester i at [i*DATA_W +: DATA_W]
//   io_req_rhs     in   REQS*DATA_W  same packing as io_req_lhs
//   io_req_cin     in   REQS         per-requester carry-in
//   io_req_sub     in   REQS         subtract select (SUB_EN builds only)
//   io_resp_valid  out  1            result valid
//   io_resp_ready  in   1            consumer accept
//   io_resp_sum    out  DATA_W       sum
//   io_resp_cout   out  1            final carry-out
//   io_resp_id     out  ID_W         requester that was served
//   io_busy        out  1            high in CALC or DONE
// ---------------------------------------------------------------------------
module serial_adder_sched
  import serial_adder_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLICE_W = SLICE_W_DEF,
  parameter int REQS    = REQS_DEF,
  parameter int ID_W    = $clog2(REQS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [REQS-1:0]          io_req_valid,
  output logic [REQS-1:0]          io_req_ready,
  input  logic [REQS*DATA_W-1:0]   io_req_lhs,
  input  logic [REQS*DATA_W-1:0]   io_req_rhs,
  input  logic [REQS-1:0]          io_req_cin,
`ifdef SERIAL_ADDER_SCHED_SUB_EN
  input  logic [REQS-1:0]          io_req_sub,
`endif
  output logic                     io_resp_valid,
  input  logic                     io_resp_ready,
  output logic [DATA_W-1:0]        io_resp_sum,
  output logic                     io_resp_cout,
  output logic [ID_W-1:0]          io_resp_id,
  output logic                     io_busy
);

  localparam int NSL   = DATA_W / SLICE_W;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q;
  logic [CNT_W-1:0]    k_q;
  logic [DATA_W-1:0]   lhs_q, rhs_q, sum_q;
  logic                carry_q, cout_q;
  logic [ID_W-1:0]     id_q;
  logic                resp_valid_q;

  logic                any_valid;
  logic [ID_W-1:0]     grant;
  logic                req_fire;
  logic                k_last;
  logic [DATA_W-1:0]   sel_lhs, sel_rhs;
  logic                sel_cin, sel_sub;
  logic [SLICE_W-1:0]  slice_a, slice_b, slice_sum;
  logic                slice_cout;

  assign any_valid = |io_req_valid;
  assign grant     = ID_W'(rr_pick(RR_MAX'(io_req_valid), 32'(last_grant_q), REQS));
  assign k_last    = (k_q == CNT_W'(NSL - 1));

  assign sel_lhs = io_req_lhs[grant*DATA_W +: DATA_W];
  assign sel_rhs = io_req_rhs[grant*DATA_W +: DATA_W];
  assign sel_cin = io_req_cin[grant];
`ifdef SERIAL_ADDER_SCHED_SUB_EN
  assign sel_sub = io_req_sub[grant];
`else
  assign sel_sub = 1'b0;
`endif

  // The single shared slice. carry_q holds cin for k=0 (loaded at the
  // handshake) and the previous slice's carry-out afterwards.
  assign slice_a = lhs_q[k_q*SLICE_W +: SLICE_W];
  assign slice_b = rhs_q[k_q*SLICE_W +: SLICE_W];

  adder_slice #(.W(SLICE_W)) u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  // Next-state and request-side outputs.
  always_comb begin
    state_d      = state_q;
    io_req_ready = '0;
    req_fire     = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so nothing looks accepted while reset is held.
        if (any_valid && reset) begin
          io_req_ready[grant] = 1'b1;
          req_fire            = 1'b1;
          state_d             = CALC;
        end
      end
      CALC: begin
        if (k_last) state_d = DONE;
      end
      DONE: begin
        if (resp_valid_q && io_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(REQS - 1);
      k_q          <= '0;
      lhs_q        <= '0;
      rhs_q        <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      cout_q       <= 1'b0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            lhs_q        <= sel_lhs;
            rhs_q        <= sel_sub ? ~sel_rhs : sel_rhs;
            carry_q      <= sel_sub ? 1'b1 : sel_cin;
            id_q         <= grant;
            last_grant_q <= grant;
            k_q          <= '0;
          end
        end
        CALC: begin
          sum_q[k_q*SLICE_W +: SLICE_W] <= slice_sum;
          carry_q                       <= slice_cout;
          if (k_last) begin
            cout_q <= slice_cout;
            k_q    <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          // First DONE cycle publishes the registered result; the response
          // handshake is only possible once io_resp_valid is visible.
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
          end else if (io_resp_ready) begin
            resp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_resp_valid = resp_valid_q;
  assign io_resp_sum   = sum_q;
  assign io_resp_cout  = cout_q;
  assign io_resp_id    = id_q;
  assign io_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_adder_sched.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_sched
// Directed self-checking bench for serial_adder_sched with default
// parameters (DATA_W=8, SLICE_W=2, REQS=2). Subtract vectors are included
// when SERIAL_ADDER_SCHED_SUB_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_adder_sched;

  localparam int DATA_W = 8;
  localparam int REQS   = 2;
  localparam int ID_W   = 1;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [REQS-1:0]        req_valid;
  logic [REQS-1:0]        req_ready;
  logic [REQS*DATA_W-1:0] req_lhs, req_rhs;
  logic [REQS-1:0]        req_cin;
`ifdef SERIAL_ADDER_SCHED_SUB_EN
  logic [REQS-1:0]        req_sub;
`endif
  logic                   resp_valid;
  logic                   resp_ready;
  logic [DATA_W-1:0]      resp_sum;
  logic                   resp_cout;
  logic [ID_W-1:0]        resp_id;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_sched dut (
    .clk           (clk),
    .reset         (reset),
    .io_req_valid  (req_valid),
    .io_req_ready  (req_ready),
    .io_req_lhs    (req_lhs),
    .io_req_rhs    (req_rhs),
    .io_req_cin    (req_cin),
`ifdef SERIAL_ADDER_SCHED_SUB_EN
    .io_req_sub    (req_sub),
`endif
    .io_resp_valid (resp_valid),
    .io_resp_ready (resp_ready),
    .io_resp_sum   (resp_sum),
    .io_resp_cout  (resp_cout),
    .io_resp_id    (resp_id),
    .io_busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request from requester idx and wait for it to be accepted.
  // Operands are scrambled right after the handshake edge.
  task automatic send(input int idx, input logic [7:0] a, input logic [7:0] b, input logic c);
    bit ok;
    ok = 1'b0;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_lhs[idx*DATA_W +: DATA_W] = a;
    req_rhs[idx*DATA_W +: DATA_W] = b;
    req_cin[idx] = c;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (req_ready[idx]) begin
        check_val("req_ready_onehot", 32'(req_ready), 32'(1) << idx);
        ok = 1'b1;
      end
      step();
    end
    check_val("req_accept", 32'(ok), 32'd1);
    req_valid = '0;
    req_lhs   = '1;
    req_rhs   = '1;
    req_cin   = '1;
  endtask

  // Counts edges until io_resp_valid is seen (bounded).
  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic check_resp(input string tag, input logic [7:0] s, input logic co, input logic id);
    $display("%s: sum=0x%02h cout=%0b id=%0d (exp 0x%02h %0b %0d)", tag, resp_sum, resp_cout, resp_id, s, co, id);
    check_val({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check_val({tag, "_sum"},   32'(resp_sum),   32'(s));
    check_val({tag, "_cout"},  32'(resp_cout),  32'(co));
    check_val({tag, "_id"},    32'(resp_id),    32'(id));
  endtask

  initial begin
    int n;
    int seen;
    logic [7:0] exp_sum [2];
    logic       exp_co  [2];
    logic       exp_id  [4];

    reset      = 1'b0;
    req_valid  = '0;
    req_lhs    = '0;
    req_rhs    = '0;
    req_cin    = '0;
`ifdef SERIAL_ADDER_SCHED_SUB_EN
    req_sub    = '0;
`endif
    resp_ready = 1'b1;

    // Reset held low for three edges.
    repeat (3) step();
    reset = 1'b1;
    check_val("rst_valid", 32'(resp_valid), 32'd0);
    check_val("rst_sum",   32'(resp_sum),   32'd0);
    check_val("rst_cout",  32'(resp_cout),  32'd0);
    check_val("rst_id",    32'(resp_id),    32'd0);
    check_val("rst_busy",  32'(busy),       32'd0);
    check_val("rst_ready", 32'(req_ready),  32'd0);
    step();
    check_val("idle_ready", 32'(req_ready), 32'd0);
    check_val("idle_busy",  32'(busy),      32'd0);

    // Req0: 0xFF + 0x01 + 0 = 0x00, carry out.
    send(0, 8'hFF, 8'h01, 1'b0);
    check_val("calc_busy", 32'(busy), 32'd1);
    wait_resp(n);
    check_val("latency0", 32'(n), 32'd5);
    check_resp("req0", 8'h00, 1'b1, 1'b0);
    step();
    check_val("resp0_drop", 32'(resp_valid), 32'd0);
    check_val("resp0_hold", 32'(resp_sum),   32'h00);
    check_val("resp0_cout_hold", 32'(resp_cout), 32'd1);

    // Req1: 0x5A + 0x35 + 1 = 0x90, no carry.
    send(1, 8'h5A, 8'h35, 1'b1);
    wait_resp(n);
    check_val("latency1", 32'(n), 32'd5);
    check_resp("req1", 8'h90, 1'b0, 1'b1);
    step();

    // Fresh reset, then both requesters valid continuously: grants 0,1,0,1.
    reset = 1'b0;
    step();
    reset = 1'b1;
    exp_sum[0] = 8'h46; exp_co[0] = 1'b0;   // 0x12 + 0x34 + 0
    exp_sum[1] = 8'h01; exp_co[1] = 1'b1;   // 0x80 + 0x80 + 1 = 0x101
    exp_id[0] = 1'b0; exp_id[1] = 1'b1; exp_id[2] = 1'b0; exp_id[3] = 1'b1;
    req_lhs   = {8'h80, 8'h12};
    req_rhs   = {8'h80, 8'h34};
    req_cin   = 2'b10;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_resp(n);
      check_resp($sformatf("rr%0d", t), exp_sum[exp_id[t]], exp_co[exp_id[t]], exp_id[t]);
      step();
    end

    // Response stall: consumer not ready for 10 cycles while both still request.
    // Last grant was 1, so requester 0 is next.
    resp_ready = 1'b0;
    wait_resp(n);
    check_resp("stall", 8'h46, 1'b0, 1'b0);
    for (int t = 0; t < 10; t++) begin
      step();
      check_val("stall_valid", 32'(resp_valid), 32'd1);
      check_val("stall_sum",   32'(resp_sum),   32'h46);
      check_val("stall_id",    32'(resp_id),    32'd0);
      check_val("stall_ready", 32'(req_ready),  32'd0);
    end
    resp_ready = 1'b1;
    step();
    req_valid = '0;
    check_val("stall_release", 32'(resp_valid), 32'd0);
    step();

    // Abort: reset asserted while k=2 in CALC.
    send(1, 8'h33, 8'h44, 1'b0);
    step();
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_val("abort_busy",  32'(busy),       32'd0);
    check_val("abort_valid", 32'(resp_valid), 32'd0);
    check_val("abort_sum",   32'(resp_sum),   32'd0);
    check_val("abort_cout",  32'(resp_cout),  32'd0);
    check_val("abort_id",    32'(resp_id),    32'd0);
    check_val("abort_ready", 32'(req_ready),  32'd0);
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (resp_valid || busy) seen++;
    end
    check_val("abort_noresp", 32'(seen), 32'd0);

`ifdef SERIAL_ADDER_SCHED_SUB_EN
    // Subtract: 0x10 - 0x20 = 0xF0 with borrow; cin ignored.
    req_sub = 2'b01;
    send(0, 8'h10, 8'h20, 1'b0);
    wait_resp(n);
    check_resp("sub0", 8'hF0, 1'b0, 1'b0);
    step();
    // 0x20 - 0x10 = 0x10, no borrow; cin=1 must not add.
    req_sub = 2'b10;
    send(1, 8'h20, 8'h10, 1'b1);
    wait_resp(n);
    check_resp("sub1", 8'h10, 1'b1, 1'b1);
    step();
    req_sub = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
